// File: rtl/secuencia.sv
// secuencia: Moore detector for runs of consecutive 1s on a serial input.
//
// The state register is a saturating run counter. z asserts while at least
// RUN_LEN consecutive high samples of w have been taken, and a single low
// sample restarts the count from zero.
//
// Ports:
//   clk    in   system clock; every state update happens on its rising edge
//   reset  in   asynchronous active-low reset that forces the idle state
//   w      in   serial data, sampled on the rising edge of clk
//   z      out  detection flag, decoded from the state register only
//
// Parameters:
//   RUN_LEN  consecutive high samples needed before z asserts (1..15)
//
// State table (cnt value):
//   state        | meaning
//   0 (ST_IDLE)  | idle: last sample was 0, or reset was just released
//   1..RUN_LEN-1 | that many consecutive 1s seen so far
//   RUN_LEN      | detect: z = 1, held while w stays high
//   > RUN_LEN    | unused code, recovers to ST_IDLE on the next edge
//
// For RUN_LEN = 2 these are the classic states A (0), B (1) and C (2).

module secuencia #(
    parameter int unsigned RUN_LEN = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic w,
    output logic z
);

    localparam int unsigned CW = (RUN_LEN < 1) ? 1 : $clog2(RUN_LEN + 1);

    localparam logic [CW-1:0] ST_IDLE = '0;
    localparam logic [CW-1:0] ST_DET  = CW'(RUN_LEN);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Any code above ST_DET is not reachable in normal operation; it goes
    // back to idle regardless of w so that a corrupted state cannot hold z.
    always_comb begin
        cnt_nxt = ST_IDLE;
        if (cnt > ST_DET) begin
            cnt_nxt = ST_IDLE;
        end else if (!w) begin
            cnt_nxt = ST_IDLE;
        end else if (cnt == ST_DET) begin
            cnt_nxt = ST_DET;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= ST_IDLE;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    // Equality decode of the registered state: there is no path from w to z.
    assign z = (cnt == ST_DET);

endmodule

// File: tb/tb_secuencia.sv
// Directed bench for secuencia: three instances (RUN_LEN = 1, 2, 4) share
// clock, reset and w, and every step compares each flag against a
// hand-computed value.

module tb_secuencia;

    logic clk;
    logic reset;
    logic w;
    logic z1;
    logic z2;
    logic z4;

    int total;
    int fails;

    secuencia #(.RUN_LEN(1)) dut1 (.clk(clk), .reset(reset), .w(w), .z(z1));
    secuencia #(.RUN_LEN(2)) dut2 (.clk(clk), .reset(reset), .w(w), .z(z2));
    secuencia #(.RUN_LEN(4)) dut4 (.clk(clk), .reset(reset), .w(w), .z(z4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive w away from the active edge, then sample all flags 1 ns after it.
    task automatic step(input string tag, input logic wv,
                        input logic e1, input logic e2, input logic e4);
        @(negedge clk);
        w = wv;
        @(posedge clk);
        #1;
        check({tag, "/z1"}, z1, e1);
        check({tag, "/z2"}, z2, e2);
        check({tag, "/z4"}, z4, e4);
    endtask

    initial begin
        total = 0;
        fails = 0;
        reset = 1'b0;
        w     = 1'b0;

        // Held in reset with w toggling (including X): all flags stay low.
        step("rst0", 1'b1,  1'b0, 1'b0, 1'b0);
        step("rst1", 1'b0,  1'b0, 1'b0, 1'b0);
        step("rst2", 1'bx,  1'b0, 1'b0, 1'b0);
        step("rst3", 1'b1,  1'b0, 1'b0, 1'b0);

        // Release; two low samples keep everything idle.
        @(negedge clk);
        reset = 1'b1;
        w     = 1'b0;
        step("idle0", 1'b0, 1'b0, 1'b0, 1'b0);
        step("idle1", 1'b0, 1'b0, 1'b0, 1'b0);

        // Held high: z1 after 1st edge, z2 after 2nd, z4 after 4th, saturating.
        step("hold1", 1'b1, 1'b1, 1'b0, 1'b0);
        step("hold2", 1'b1, 1'b1, 1'b1, 1'b0);
        step("hold3", 1'b1, 1'b1, 1'b1, 1'b0);
        step("hold4", 1'b1, 1'b1, 1'b1, 1'b1);
        step("hold5", 1'b1, 1'b1, 1'b1, 1'b1);
        step("hold6", 1'b1, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset mid-run: flags drop before any clock edge.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async/z1", z1, 1'b0);
        check("async/z2", z2, 1'b0);
        check("async/z4", z4, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        w     = 1'b0;

        // First edge after release is sample 1 of a new run.
        step("single1", 1'b1, 1'b1, 1'b0, 1'b0);
        step("single2", 1'b0, 1'b0, 1'b0, 1'b0);
        step("single3", 1'b0, 1'b0, 1'b0, 1'b0);

        // Run break 1,1,0,1,1,1.
        step("brk1", 1'b1, 1'b1, 1'b0, 1'b0);
        step("brk2", 1'b1, 1'b1, 1'b1, 1'b0);
        step("brk3", 1'b0, 1'b0, 1'b0, 1'b0);
        step("brk4", 1'b1, 1'b1, 1'b0, 1'b0);
        step("brk5", 1'b1, 1'b1, 1'b1, 1'b0);
        step("brk6", 1'b1, 1'b1, 1'b1, 1'b0);
        step("brk7", 1'b0, 1'b0, 1'b0, 1'b0);

        // Alternating pattern: only the RUN_LEN=1 flag ever asserts.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0)
                step("alt_hi", 1'b1, 1'b1, 1'b0, 1'b0);
            else
                step("alt_lo", 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // RUN_LEN=4 sequence 1,1,1,0,1,1,1,1: z4 only after the 8th edge.
        step("r4_1", 1'b1, 1'b1, 1'b0, 1'b0);
        step("r4_2", 1'b1, 1'b1, 1'b1, 1'b0);
        step("r4_3", 1'b1, 1'b1, 1'b1, 1'b0);
        step("r4_4", 1'b0, 1'b0, 1'b0, 1'b0);
        step("r4_5", 1'b1, 1'b1, 1'b0, 1'b0);
        step("r4_6", 1'b1, 1'b1, 1'b1, 1'b0);
        step("r4_7", 1'b1, 1'b1, 1'b1, 1'b0);
        step("r4_8", 1'b1, 1'b1, 1'b1, 1'b1);
        step("r4_9", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
